// File: rtl/usb_tx_arbiter_if.sv
// Byte-wide AXI-stream link between the transmit arbiter and the packet encoder.
// The master drives data/valid/last; the consumer drives ready.
interface axi_stream_iface;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/usb_tx_arbiter.sv
// Packet-level arbiter for the USB transmit stream: source 0 (handshakes) has strict
// priority, the remaining sources share round-robin, with an enforced inter-packet gap.
module usb_tx_arbiter #(
  parameter int N_SRC      = 4,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_LEN    = 1027
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SRC-1:0]   src_tvalid,
  input  logic [8*N_SRC-1:0] src_tdata,
  input  logic [N_SRC-1:0]   src_tlast,
  output logic [N_SRC-1:0]   src_tready,
  axi_stream_iface.master    tx,
  output logic [N_SRC-1:0]   grant,
  output logic               busy,
  output logic               err_len
);

  localparam int IW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_PKT, S_DRAIN, S_GAP} state_t;

  state_t           state, state_nxt, after_pkt;
  logic [N_SRC-1:0] grant_q, grant_nxt;
  logic [IW-1:0]    gidx, gidx_nxt;
  logic [IW-1:0]    rr_ptr, rr_nxt;
  logic [CW-1:0]    beat_cnt, beat_nxt;
  logic [3:0]       gap_cnt, gap_nxt;
  logic             err_nxt;
  logic             forced_last;
  logic [7:0]       gdata;

  logic [IW-1:0]    pick;
  logic             pick_ok;
  logic [IW:0]      cand;

  // Source 0 wins outright; otherwise scan rr_ptr..N_SRC-1 then 1..rr_ptr-1.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    if (src_tvalid[0]) begin
      pick_ok = 1'b1;
    end else begin
      for (int off = 0; off < N_SRC - 1; off++) begin
        cand = {1'b0, rr_ptr} + (IW+1)'(off);
        if (cand >= (IW+1)'(N_SRC))
          cand = cand - (IW+1)'(N_SRC - 1);
        if (!pick_ok && src_tvalid[cand[IW-1:0]]) begin
          pick_ok = 1'b1;
          pick    = cand[IW-1:0];
        end
      end
    end
  end

  assign gdata       = src_tdata[{gidx, 3'b000} +: 8];
  assign forced_last = (beat_cnt == CW'(MAX_LEN - 1));
  assign after_pkt   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_q;
    gidx_nxt   = gidx;
    rr_nxt     = rr_ptr;
    beat_nxt   = beat_cnt;
    gap_nxt    = gap_cnt;
    err_nxt    = 1'b0;
    tx.tvalid  = 1'b0;
    tx.tdata   = 8'h00;
    tx.tlast   = 1'b0;
    src_tready = '0;

    case (state)
      S_IDLE: begin
        if (pick_ok) begin
          state_nxt = S_PKT;
          gidx_nxt  = pick;
          grant_nxt = N_SRC'(1) << pick;
          beat_nxt  = '0;
          if (pick != '0)
            rr_nxt = (pick == IW'(N_SRC - 1)) ? IW'(1) : pick + 1'b1;
        end
      end

      S_PKT: begin
        tx.tvalid        = src_tvalid[gidx];
        tx.tdata         = src_tvalid[gidx] ? gdata : 8'h00;
        tx.tlast         = src_tlast[gidx] | forced_last;
        src_tready[gidx] = tx.tready;
        if (tx.tvalid && tx.tready) begin
          beat_nxt = beat_cnt + 1'b1;
          if (src_tlast[gidx]) begin
            state_nxt = after_pkt;
            grant_nxt = '0;
            gap_nxt   = 4'(GAP_CYCLES);
          end else if (forced_last) begin
            state_nxt = S_DRAIN;
            err_nxt   = 1'b1;
          end
        end
      end

      // Runaway packet: swallow the rest of it so the source can finish cleanly.
      S_DRAIN: begin
        src_tready[gidx] = 1'b1;
        if (src_tvalid[gidx] && src_tlast[gidx]) begin
          state_nxt = after_pkt;
          grant_nxt = '0;
          gap_nxt   = 4'(GAP_CYCLES);
        end
      end

      S_GAP: begin
        gap_nxt = gap_cnt - 1'b1;
        if (gap_cnt <= 4'd1)
          state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      grant_q  <= '0;
      gidx     <= '0;
      rr_ptr   <= IW'(1);
      beat_cnt <= '0;
      gap_cnt  <= '0;
      err_len  <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      gidx     <= gidx_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= beat_nxt;
      gap_cnt  <= gap_nxt;
      err_len  <= err_nxt;
    end
  end

  assign grant = grant_q;
  assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter (4 sources, 2-cycle gap, MAX_LEN shortened to 4
// so truncation can be exercised with short packets).
module tb_usb_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  src_tvalid;
  logic [31:0] src_tdata;
  logic [3:0]  src_tlast;
  logic [3:0]  src_tready;
  logic [3:0]  grant;
  logic        busy;
  logic        err_len;

  axi_stream_iface txIf ();

  usb_tx_arbiter #(.N_SRC(4), .GAP_CYCLES(2), .MAX_LEN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_tvalid (src_tvalid),
    .src_tdata  (src_tdata),
    .src_tlast  (src_tlast),
    .src_tready (src_tready),
    .tx         (txIf),
    .grant      (grant),
    .busy       (busy),
    .err_len    (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  // Simple packet source model: each source streams base, base+1, ... for len beats.
  logic [7:0] srcBase [4];
  int         srcLen  [4];
  int         srcPos  [4];

  task applyStimulus();
    for (int s = 0; s < 4; s++) begin
      if (srcPos[s] < srcLen[s]) begin
        src_tvalid[s]        = 1'b1;
        src_tdata[8*s +: 8]  = srcBase[s] + 8'(srcPos[s]);
        src_tlast[s]         = (srcPos[s] == srcLen[s] - 1);
      end else begin
        src_tvalid[s]        = 1'b0;
        src_tdata[8*s +: 8]  = 8'h00;
        src_tlast[s]         = 1'b0;
      end
    end
  endtask

  task loadPkt(input int s, input int len, input logic [7:0] base);
    srcBase[s] = base;
    srcLen[s]  = len;
    srcPos[s]  = 0;
    applyStimulus();
  endtask

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check one cycle's outputs, then advance a clock and step the source model.
  task runCycle(input string tag, input logic v, input logic [7:0] d, input logic l,
                input logic [3:0] g, input logic [3:0] rdy, input logic b, input logic e);
    logic [3:0] hs;
    #1;
    checkOutput({tag, ".tvalid"}, 32'(txIf.tvalid), 32'(v));
    checkOutput({tag, ".tdata"},  32'(txIf.tdata),  32'(d));
    checkOutput({tag, ".tlast"},  32'(txIf.tlast),  32'(l));
    checkOutput({tag, ".grant"},  32'(grant),       32'(g));
    checkOutput({tag, ".ready"},  32'(src_tready),  32'(rdy));
    checkOutput({tag, ".busy"},   32'(busy),        32'(b));
    checkOutput({tag, ".err"},    32'(err_len),     32'(e));
    hs = src_tvalid & src_tready;
    @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++)
      if (hs[s]) srcPos[s]++;
    applyStimulus();
  endtask

  task beats(input string tag, input logic [7:0] base, input int len, input logic [3:0] g);
    for (int i = 0; i < len; i++)
      runCycle(tag, 1'b1, base + 8'(i), (i == len - 1), g, g, 1'b1, 1'b0);
  endtask

  // Two gap cycles then one idle cycle follow every packet.
  task postPacket(input string tag);
    runCycle({tag, "_gap1"}, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    runCycle({tag, "_gap2"}, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    runCycle({tag, "_idle"}, 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  task checkResetOutputs(input string tag);
    checkOutput({tag, ".tvalid"}, 32'(txIf.tvalid), 32'd0);
    checkOutput({tag, ".tdata"},  32'(txIf.tdata),  32'd0);
    checkOutput({tag, ".tlast"},  32'(txIf.tlast),  32'd0);
    checkOutput({tag, ".grant"},  32'(grant),       32'd0);
    checkOutput({tag, ".ready"},  32'(src_tready),  32'd0);
    checkOutput({tag, ".busy"},   32'(busy),        32'd0);
    checkOutput({tag, ".err"},    32'(err_len),     32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    txIf.tready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      srcBase[s] = 8'h00;
      srcLen[s]  = 0;
      srcPos[s]  = 0;
    end
    applyStimulus();
    #2;
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single ACK from source 0
    loadPkt(0, 1, 8'hD2);
    runCycle("ack_idle", 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    runCycle("ack_beat", 1'b1, 8'hD2, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0);
    postPacket("ack");

    // Round-robin 1,2,3 then 1 again
    loadPkt(1, 3, 8'h11);
    loadPkt(2, 3, 8'h21);
    loadPkt(3, 3, 8'h31);
    runCycle("rr_idle", 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    beats("rr_s1a", 8'h11, 3, 4'b0010);
    loadPkt(1, 3, 8'h14);
    postPacket("rr_s1a");
    beats("rr_s2", 8'h21, 3, 4'b0100);
    postPacket("rr_s2");
    beats("rr_s3", 8'h31, 3, 4'b1000);
    postPacket("rr_s3");
    beats("rr_s1b", 8'h14, 3, 4'b0010);
    postPacket("rr_s1b");

    // Truncation: 6-beat packet against MAX_LEN=4
    loadPkt(1, 6, 8'h01);
    runCycle("trunc_idle", 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    beats("trunc", 8'h01, 4, 4'b0010);
    runCycle("trunc_drain1", 1'b0, 8'h00, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1);
    runCycle("trunc_drain2", 1'b0, 8'h00, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0);
    postPacket("trunc");

    // Priority: source 0 waits for src2 to finish, then beats pending src3
    loadPkt(2, 3, 8'h41);
    runCycle("prio_idle", 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    runCycle("prio_s2b0", 1'b1, 8'h41, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0);
    loadPkt(0, 1, 8'h4B);
    loadPkt(3, 4, 8'h61);
    loadPkt(1, 1, 8'h71);
    runCycle("prio_s2b1", 1'b1, 8'h42, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0);
    runCycle("prio_s2b2", 1'b1, 8'h43, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0);
    postPacket("prio_s2");
    runCycle("prio_s0", 1'b1, 8'h4B, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0);
    postPacket("prio_s0");

    // Backpressure on src3 (rr_ptr 3 picks src3 over src1)
    runCycle("bp0", 1'b1, 8'h61, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0);
    txIf.tready = 1'b0;
    runCycle("bp1", 1'b1, 8'h62, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0);
    txIf.tready = 1'b1;
    runCycle("bp2", 1'b1, 8'h62, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0);
    txIf.tready = 1'b0;
    runCycle("bp3", 1'b1, 8'h63, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0);
    txIf.tready = 1'b1;
    runCycle("bp4", 1'b1, 8'h63, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0);
    txIf.tready = 1'b0;
    runCycle("bp5", 1'b1, 8'h64, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0);
    txIf.tready = 1'b1;
    runCycle("bp6", 1'b1, 8'h64, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0);
    postPacket("bp");
    runCycle("prio_s1", 1'b1, 8'h71, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0);
    postPacket("prio_s1");

    // Reset mid-packet, then rr_ptr must be back at 1
    loadPkt(2, 4, 8'h81);
    runCycle("rst_idle", 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    runCycle("rst_b0", 1'b1, 8'h81, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0);
    runCycle("rst_b1", 1'b1, 8'h82, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst_async");
    @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) srcLen[s] = 0;
    loadPkt(2, 1, 8'h91);
    loadPkt(3, 1, 8'hA1);
    rst_n = 1'b1;
    runCycle("rel_idle", 1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    runCycle("rel_s2", 1'b1, 8'h91, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0);
    postPacket("rel_s2");
    runCycle("rel_s3", 1'b1, 8'hA1, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0);
    postPacket("rel_s3");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/usb_tx_arbiter.md
# usb_tx_arbiter

Packet-level arbiter sharing the single 8-bit USB transmit AXI-stream between several packet sources: the transaction layer's handshake generator and the IN-endpoint data engines. Source 0 has strict priority (handshakes must meet the bus turnaround window). Sources 1..N_SRC-1 are served round-robin. The block enforces a configurable inter-packet gap and truncates runaway packets. It sits between the transaction/endpoint logic and the packet encoder that consumes `tx`.

## Interface
- N_SRC, 4, number of sources (2..8); source 0 = handshake generator
- GAP_CYCLES, 2, idle clocks enforced after each packet's last beat (0..15)
- MAX_LEN, 1027, maximum beats per packet (PID + 1024 data + 2 CRC)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- src_tvalid  in  N_SRC  per-source beat valid
- src_tdata  in  8*N_SRC  per-source byte; source i at [8i+7:8i]
- src_tlast  in  N_SRC  per-source last beat of packet
- src_tready  out  N_SRC  per-source ready
- tx  axi_stream_iface.master  8-bit data  merged stream to packet encoder
- grant  out  N_SRC  one-hot current owner; 0 when none
- busy  out  1  high in any state except S_IDLE
- err_len  out  1  one-cycle pulse when a packet is truncated at MAX_LEN

## Operation
- States: S_IDLE, S_PKT, S_DRAIN, S_GAP.
- S_IDLE, arbitration, evaluated when any src_tvalid is high:
  - If src_tvalid[0] is high, grant source 0.
  - Otherwise grant the first valid source at or after rr_ptr, scanning rr_ptr..N_SRC-1 then 1..rr_ptr-1.
  - Register grant, clear beat counter, go to S_PKT.
- rr_ptr: range 1..N_SRC-1, reset value 1. When a source k≥1 is granted, rr_ptr <= k+1, wrapping N_SRC to 1. A source 0 grant leaves rr_ptr unchanged.
- S_PKT:
  - tx.tvalid = src_tvalid[g], tx.tdata = src_tdata[g], src_tready[g] = tx.tready; all other src_tready are 0.
  - tx.tlast = src_tlast[g] OR (beat counter == MAX_LEN-1).
  - The beat counter (width $clog2(MAX_LEN+1)) increments on each tx.tvalid & tx.tready.
  - On a handshake with src_tlast[g]: go to S_GAP.
  - On a handshake with forced tlast and src_tlast[g] low: pulse err_len and go to S_DRAIN.
- S_DRAIN:
  - src_tready[g] = 1, tx.tvalid = 0; source beats are discarded.
  - On src_tvalid[g] & src_tlast[g]: go to S_GAP.
- S_GAP:
  - Load gap counter with GAP_CYCLES on entry. Count down one per clock.
  - Go to S_IDLE when it reaches 0.
  - GAP_CYCLES = 0: S_PKT/S_DRAIN go directly to S_IDLE instead.
- grant holds its value through S_PKT and S_DRAIN, and clears to 0 on leaving them.
- Source 0 never pre-empts a packet in progress; it waits for S_IDLE.

## Timing
- Reset (async assert, sync deassert assumed upstream): state S_IDLE, grant 0, rr_ptr 1, all counters 0, tx.tvalid 0, tx.tlast 0, tx.tdata 0, src_tready 0, busy 0, err_len 0.
- Arbitration latency: a src_tvalid seen in S_IDLE at edge n puts the first beat on tx in cycle n+1. tx is combinational from src in S_PKT, so there is no per-beat bubble.
- tx.tdata is 0 whenever tx.tvalid is 0.
- Throughput: a full-rate source with tready held high moves 1 beat per clock.
- Minimum spacing, last beat to next first beat: GAP_CYCLES + 1 idle clocks on tx.
- Requests sampled in S_GAP are not granted until S_IDLE; only the state at the S_IDLE edge matters.
- Simultaneous requests: source 0 always wins. Among the others, the lowest index at or after rr_ptr wins.
- Single-beat packets (tvalid & tlast on the first beat) are legal.
- A source lowering tvalid mid-packet stalls tx; the grant is held indefinitely and there is no timeout.
- rst_n assertion mid-packet aborts immediately. The source is responsible for discarding its partial packet.

## Test plan
- Single ACK: src0 sends 0xD2 with tlast at cycle 0 while idle -> tx beat 0xD2 with tlast in cycle 1; grant=0001 for exactly 1 cycle; busy high for 1 + GAP_CYCLES cycles.
- Round-robin: src1, src2, src3 each hold a 3-byte packet pending -> served in order 1,2,3; with src1 re-requesting after its packet, order is 1,2,3,1; each packet is followed by 2 idle cycles.
- Priority: src2 is mid-packet when src0 raises valid -> src2 finishes uninterrupted; src0 is granted next, ahead of a pending src3; rr_ptr stays 3.
- Truncation: MAX_LEN=4, src1 sends 6 bytes 0x01..0x06 -> tx shows 0x01..0x04 with tlast on 0x04; err_len pulses once; 0x05 and 0x06 are accepted and dropped; GAP follows.
- Backpressure: tx.tready toggles 1,0,1,0 during a 4-byte src3 packet -> bytes appear unduplicated and in order; src3's tready mirrors tx.tready; all other src_tready stay 0.
- Reset mid-packet: rst_n is pulled low after the 2nd byte -> all outputs return to their reset values asynchronously; after release, the next request is arbitrated with rr_ptr=1.
